// File: rtl/trail_uip_walker_pkg.sv
// Shared types for the 1-UIP trail walker: FSM states, the decision-reason
// marker, and the layout of one trail read-port entry.
package trail_uip_walker_pkg;

  localparam logic [15:0] REASON_NONE = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_MARKS = 2'd1,
    S_SCAN       = 2'd2,
    S_EMIT       = 2'd3
  } walker_state_t;

  typedef struct packed {
    logic [31:0] var_id;
    logic        value;
    logic [15:0] level;
    logic [15:0] reason;
  } trail_rd_entry_t;

endpackage

// File: rtl/trail_uip_walker_if.sv
// Bundle of the walker's control, marking, trail read-port and emit signals.
// master = analyzer/trail side, slave = walker.
interface trail_uip_walker_if;
  logic        start;
  logic [15:0] conflict_level;
  logic [15:0] trail_height;
  logic        abort;
  logic        mark_valid;
  logic [31:0] mark_var;
  logic [15:0] mark_level;
  logic        marks_done;
  logic [15:0] trail_read_idx;
  logic [31:0] trail_read_var;
  logic        trail_read_value;
  logic [15:0] trail_read_level;
  logic [15:0] trail_read_reason;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_var;
  logic        out_value;
  logic [15:0] out_reason;
  logic [15:0] out_idx;
  logic        out_is_uip;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, conflict_level, trail_height, abort,
    output mark_valid, mark_var, mark_level, marks_done,
    input  trail_read_idx,
    output trail_read_var, trail_read_value, trail_read_level, trail_read_reason,
    input  out_valid,
    output out_ready,
    input  out_var, out_value, out_reason, out_idx, out_is_uip,
    input  busy, done, error
  );

  modport slave (
    input  start, conflict_level, trail_height, abort,
    input  mark_valid, mark_var, mark_level, marks_done,
    output trail_read_idx,
    input  trail_read_var, trail_read_value, trail_read_level, trail_read_reason,
    output out_valid,
    input  out_ready,
    output out_var, out_value, out_reason, out_idx, out_is_uip,
    output busy, done, error
  );
endinterface

// File: rtl/trail_uip_walker_seen_bitvec.sv
// Per-variable seen flags: synchronous set of one bit, synchronous clear of
// all bits, and two independent combinational test ports.
module seen_bitvec #(
  parameter  int unsigned N  = 256,
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_set,
  input  logic [AW-1:0] i_set_idx,
  input  logic [AW-1:0] i_test_a_idx,
  input  logic [AW-1:0] i_test_b_idx,
  output logic          o_test_a,
  output logic          o_test_b
);
  logic [N-1:0] r_bits;

  // Clear-all wins over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_bits <= '0;
    else if (i_clear) r_bits <= '0;
    else if (i_set)   r_bits[i_set_idx] <= 1'b1;
  end

  assign o_test_a = r_bits[i_test_a_idx];
  assign o_test_b = r_bits[i_test_b_idx];
endmodule

// File: rtl/trail_uip_walker.sv
// Backward trail walker for 1-UIP conflict analysis: tracks marked variables,
// counts pending conflict-level marks, and emits each marked conflict-level
// trail entry newest-first, flagging the first UIP.
module trail_uip_walker
  import trail_uip_walker_pkg::*;
#(
  parameter int unsigned MAX_VARS = 256,
  parameter int unsigned CNT_W    = 16
) (
  input logic               clk,
  input logic               reset,
  trail_uip_walker_if.slave bus
);
  localparam int unsigned AW = (MAX_VARS > 1) ? $clog2(MAX_VARS) : 1;

  walker_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]     r_idx;
  logic [15:0]     r_level;
  logic            r_error;
  logic            r_done;
  logic            r_out_valid;
  logic [31:0]     r_out_var;
  logic            r_out_value;
  logic [15:0]     r_out_reason;
  logic [15:0]     r_out_idx;
  logic            r_out_is_uip;

  trail_rd_entry_t  w_rd;
  logic             w_seen_mark;
  logic             w_seen_rd;
  logic             w_mark_in_range;
  logic             w_rd_in_range;
  logic             w_mark_active;
  logic             w_mark_new;
  logic             w_mark_counted;
  logic             w_mark_bad;
  logic             w_accept;
  logic             w_hit;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_cnt_ovf;
  logic [15:0]      w_rd_idx;

  assign w_rd = '{var_id: bus.trail_read_var, value: bus.trail_read_value,
                  level: bus.trail_read_level, reason: bus.trail_read_reason};

  assign w_mark_in_range = bus.mark_var < 32'(MAX_VARS);
  assign w_rd_in_range   = w_rd.var_id  < 32'(MAX_VARS);
  assign w_mark_active   = bus.mark_valid && (r_state != S_IDLE);
  assign w_mark_new      = w_mark_active && w_mark_in_range && !w_seen_mark;
  assign w_mark_counted  = w_mark_new && (bus.mark_level == r_level);
  assign w_mark_bad      = w_mark_active && !w_mark_in_range;
  assign w_accept        = (r_state == S_EMIT) && bus.out_ready;
  // Out-of-range trail variables read as unseen rather than aliasing.
  assign w_hit = (r_state == S_SCAN) && (r_idx != '0) && w_rd_in_range &&
                 w_seen_rd && (w_rd.level == r_level);
  assign w_rd_idx = ((r_state == S_SCAN) && (r_idx != '0)) ? r_idx - 16'd1 : '0;

  seen_bitvec #(.N(MAX_VARS)) u_seen (
    .clk          (clk),
    .rst          (reset),
    .i_clear      (bus.start),
    .i_set        (w_mark_new && !bus.abort),
    .i_set_idx    (bus.mark_var[AW-1:0]),
    .i_test_a_idx (bus.mark_var[AW-1:0]),
    .i_test_b_idx (w_rd.var_id[AW-1:0]),
    .o_test_a     (w_seen_mark),
    .o_test_b     (w_seen_rd)
  );

  // Net pending-mark count: a counted mark and an accepted emit cancel out.
  always_comb begin
    w_cnt_next = r_cnt;
    w_cnt_ovf  = 1'b0;
    if (w_mark_counted && !w_accept) begin
      if (&r_cnt) w_cnt_ovf  = 1'b1;
      else        w_cnt_next = r_cnt + CNT_W'(1);
    end else if (!w_mark_counted && w_accept && (r_cnt != '0)) begin
      w_cnt_next = r_cnt - CNT_W'(1);
    end
  end

  // Walker FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_level      <= '0;
      r_error      <= 1'b0;
      r_done       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_var    <= '0;
      r_out_value  <= 1'b0;
      r_out_reason <= REASON_NONE;
      r_out_idx    <= '0;
      r_out_is_uip <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.start) begin
        r_state     <= S_WAIT_MARKS;
        r_cnt       <= '0;
        r_idx       <= bus.trail_height;
        r_level     <= bus.conflict_level;
        r_error     <= 1'b0;
        r_out_valid <= 1'b0;
      end else if (bus.abort) begin
        r_state     <= S_IDLE;
        r_out_valid <= 1'b0;
      end else begin
        if (r_state != S_IDLE) begin
          r_cnt <= w_cnt_next;
          if (w_cnt_ovf || w_mark_bad) r_error <= 1'b1;
        end
        case (r_state)
          S_IDLE: ;
          S_WAIT_MARKS: begin
            if (bus.marks_done) begin
              if (w_cnt_next == '0) begin
                r_error <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_SCAN;
              end
            end
          end
          S_SCAN: begin
            if (r_idx == '0) begin
              r_error <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx - 16'd1;
              if (w_hit) begin
                r_out_valid  <= 1'b1;
                r_out_var    <= w_rd.var_id;
                r_out_value  <= w_rd.value;
                r_out_reason <= w_rd.reason;
                r_out_idx    <= w_rd_idx;
                r_out_is_uip <= (w_cnt_next == CNT_W'(1));
                r_state      <= S_EMIT;
              end
            end
          end
          S_EMIT: begin
            // A conflict-level mark arriving while an entry is pending means
            // more work remains, so that entry can no longer be the UIP.
            if (w_accept) begin
              r_out_valid <= 1'b0;
              if (r_out_is_uip && !w_mark_counted) begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_WAIT_MARKS;
              end
            end else if (w_mark_counted) begin
              r_out_is_uip <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.trail_read_idx = w_rd_idx;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_var        = r_out_var;
  assign bus.out_value      = r_out_value;
  assign bus.out_reason     = r_out_reason;
  assign bus.out_idx        = r_out_idx;
  assign bus.out_is_uip     = r_out_is_uip;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.done           = r_done;
  assign bus.error          = r_error;
endmodule
